// File: rtl/unary_run_packer_pkg.sv
// Shared codec definitions for the unary run packer and its matching decoder model.
// The insertion mask helper places k bits MSB-first, starting just after `fill` occupied bits.
package unary_run_packer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        TERM  = 2'd2,
        FLUSH = 2'd3
    } packer_state_t;

    localparam int DEF_OUT_W = 4;
    localparam int DEF_CNT_W = 8;
    localparam int MASK_W    = 32;

    // Bit positions [w-1-fill] down to [w-fill-k] set; the caller slices to its word width.
    function automatic logic [MASK_W-1:0] fill_mask(input int fill, input int k, input int w);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if ((i < w - fill) && (i >= w - fill - k)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/unary_run_packer_bit_accumulator.sv
// MSB-first bit accumulator: appends k copies of a bit plus an optional opposite terminator bit.
// A clear empties the word in the same cycle that new bits are appended behind it.
module bit_accumulator
    import unary_run_packer_pkg::*;
#(
    parameter int OUT_W  = DEF_OUT_W,
    parameter int FILL_W = $clog2(DEF_OUT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              app_en,
    input  logic              app_bit,
    input  logic [FILL_W-1:0] app_k,
    input  logic              term_en,
    output logic [OUT_W-1:0]  acc,
    output logic [FILL_W-1:0] fill,
    output logic              full
);

    logic [OUT_W-1:0]  base_acc;
    int                base_fill;
    logic [MASK_W-1:0] run_m;
    logic [MASK_W-1:0] term_m;
    logic [OUT_W-1:0]  acc_n;
    int                fill_n;

    assign full = (fill == FILL_W'(OUT_W));

    // Bits beyond `fill` are always zero, so appending is a plain OR of the masks.
    always_comb begin
        base_acc  = clear ? '0 : acc;
        base_fill = clear ? 0 : int'(fill);
        run_m     = fill_mask(base_fill, int'(app_k), OUT_W);
        term_m    = fill_mask(base_fill + int'(app_k), 1, OUT_W);
        acc_n     = base_acc;
        fill_n    = base_fill;
        if (app_en) begin
            if (app_bit) begin
                acc_n = acc_n | run_m[OUT_W-1:0];
            end
            if (term_en && !app_bit) begin
                acc_n = acc_n | term_m[OUT_W-1:0];
            end
            fill_n = base_fill + int'(app_k) + (term_en ? 1 : 0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            fill <= '0;
        end else begin
            acc  <= acc_n;
            fill <= FILL_W'(fill_n);
        end
    end

endmodule

// File: rtl/unary_run_packer.sv
// Unary run packer: each symbol (N, L) becomes N copies of L plus a ~L terminator, packed MSB-first.
// Holds the symbol FSM, the remaining-run counter and the output word register.
module unary_run_packer
    import unary_run_packer_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] in_count,
    input  logic             in_leading_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_word,
    output logic             out_last,
    output logic             busy
);

    localparam int FILL_W = $clog2(OUT_W + 1);

    packer_state_t     state, state_n;
    logic [CNT_W-1:0]  rem, rem_n;
    logic              lead_bit;
    logic              last_flag;
    logic              pad_bit;
    logic              accept;

    logic [OUT_W-1:0]  acc;
    logic [FILL_W-1:0] fill;
    logic              full;
    logic              do_xfer;
    logic              app_en;
    logic              app_bit;
    logic [FILL_W-1:0] app_k;
    logic              term_en;
    int                space;
    int                run_k;

    // A full accumulator drains into the output register whenever that register is free.
    assign do_xfer = full && (!out_valid || out_ready);
    assign space   = do_xfer ? OUT_W : (OUT_W - int'(fill));
    assign busy    = (state != IDLE) || (fill != '0) || out_valid;

    bit_accumulator #(
        .OUT_W  (OUT_W),
        .FILL_W (FILL_W)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (do_xfer),
        .app_en  (app_en),
        .app_bit (app_bit),
        .app_k   (app_k),
        .term_en (term_en),
        .acc     (acc),
        .fill    (fill),
        .full    (full)
    );

    always_comb begin
        state_n  = state;
        rem_n    = rem;
        accept   = 1'b0;
        app_en   = 1'b0;
        app_bit  = lead_bit;
        app_k    = '0;
        term_en  = 1'b0;
        run_k    = 0;
        in_ready = (state == IDLE) && !full;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    rem_n   = in_count;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (space > 0) begin
                    run_k  = (int'(rem) < space) ? int'(rem) : space;
                    app_en = 1'b1;
                    app_k  = FILL_W'(run_k);
                    rem_n  = rem - CNT_W'(run_k);
                    if (rem_n == '0) begin
                        if (run_k < space) begin
                            term_en = 1'b1;
                            state_n = last_flag ? FLUSH : IDLE;
                        end else begin
                            state_n = TERM;
                        end
                    end
                end
            end
            TERM: begin
                if (space > 0) begin
                    app_en  = 1'b1;
                    term_en = 1'b1;
                    state_n = last_flag ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                // Pad with the last run bit so the padding can never look like a terminator.
                if (full) begin
                    if (do_xfer) begin
                        state_n = IDLE;
                    end
                end else if (fill != '0) begin
                    app_en  = 1'b1;
                    app_bit = pad_bit;
                    app_k   = FILL_W'(OUT_W) - fill;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            lead_bit  <= 1'b0;
            last_flag <= 1'b0;
            pad_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_last  <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            if (accept) begin
                lead_bit  <= in_leading_bit;
                last_flag <= in_last;
                pad_bit   <= in_leading_bit;
            end
            // The only word transferred while in FLUSH is the final word of the stream.
            if (do_xfer) begin
                out_valid <= 1'b1;
                out_word  <= acc;
                out_last  <= (state == FLUSH);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    a_out_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_word) && $stable(out_last)));

endmodule
